// File: rtl/wb_sertx_sched_pkg.sv
// Shared types and constants for the serializer TX scheduler.
// The idle frame is three K28.5 words, so the far end keeps symbol lock when no client is active.
package wb_sertx_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_GAP
    } state_t;

    localparam int FRAME_W = 27;
    localparam int WORD_W  = 9;

    localparam logic [WORD_W-1:0]  K28_5      = 9'h1BC;
    localparam logic [FRAME_W-1:0] IDLE_FRAME = {3{K28_5}};

endpackage

// File: rtl/serdes_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: the lowest requester at or above the pointer wins.
// If no requester sits at or above the pointer, the pick wraps to the lowest requester overall.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    logic [NUM_REQ-1:0] masked;

    always_comb begin
        masked = '0;
        winner = '0;
        valid  = |req;
        for (int i = 0; i < NUM_REQ; i++) begin
            masked[i] = req[i] && (IDX_W'(i) >= pointer);
        end
        // Descending scans leave the lowest set index; the masked pass overrides the wrap pass.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) winner = IDX_W'(i);
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (masked[i]) winner = IDX_W'(i);
        end
    end

endmodule

// File: rtl/serdes_tx_scheduler.sv
// Shares one serializer lane between NUM_REQ requesters, one frame in flight, with idle-frame fill.
// The frame is latched in idle; start and grant fire one cycle later; done and abort fire after eot or timeout.
module serdes_tx_scheduler
    import wb_sertx_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int IDLE_PERIOD = 64,
    parameter int TIMEOUT     = 1024
) (
    input  logic                       CLK_I,
    input  logic                       RST_I,
    input  logic                       enable_i,
    input  logic                       idle_ena_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*FRAME_W-1:0] frame_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [NUM_REQ-1:0]         done_o,
    output logic                       ser_start_o,
    output logic [31:0]                ser_data_o,
    input  logic                       ser_eot_i,
    output logic                       busy_o,
    output logic                       err_o,
    output logic                       abort_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int Q_W   = $clog2(IDLE_PERIOD + 1);
    localparam int G_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     ptr, owner, arb_winner;
    logic                 owner_vld, arb_vld;
    logic [FRAME_W-1:0]   frame_q, sel_frame;
    logic [TMO_W-1:0]     tmo_cnt;
    logic [Q_W-1:0]       quiet_cnt;
    logic [G_W-1:0]       gap_cnt;
    logic [NUM_REQ-1:0]   done_q;
    logic                 abort_q, err_q;
    logic                 grant_go, idle_go, quiet_hit, eot_hit, tmo_hit, gap_last;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (req_i),
        .pointer (ptr),
        .winner  (arb_winner),
        .valid   (arb_vld)
    );

    always_comb begin
        sel_frame = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_winner == IDX_W'(i)) sel_frame = frame_i[i*FRAME_W +: FRAME_W];
        end
    end

    assign grant_go  = (state == S_IDLE) && enable_i && arb_vld;
    assign quiet_hit = (quiet_cnt == Q_W'(IDLE_PERIOD - 1));
    assign idle_go   = (state == S_IDLE) && !grant_go && enable_i && idle_ena_i && quiet_hit;
    // An eot landing on the last allowed wait cycle still counts as a clean completion.
    assign eot_hit   = (state == S_WAIT) && ser_eot_i;
    assign tmo_hit   = (state == S_WAIT) && !ser_eot_i && (tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign gap_last  = (gap_cnt == G_W'(GAP_CYCLES - 1));

    always_comb begin
        state_nxt   = state;
        ser_start_o = 1'b0;
        gnt_o       = '0;
        busy_o      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (grant_go || idle_go) state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                ser_start_o = 1'b1;
                if (owner_vld) gnt_o[owner] = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (eot_hit || tmo_hit) state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                if (gap_last) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state     <= S_IDLE;
            ptr       <= '0;
            owner     <= '0;
            owner_vld <= 1'b0;
            frame_q   <= '0;
            tmo_cnt   <= '0;
            quiet_cnt <= '0;
            gap_cnt   <= '0;
            done_q    <= '0;
            abort_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state   <= state_nxt;
            done_q  <= '0;
            abort_q <= 1'b0;

            if (grant_go) begin
                owner     <= arb_winner;
                owner_vld <= 1'b1;
                frame_q   <= sel_frame;
            end else if (idle_go) begin
                owner_vld <= 1'b0;
                frame_q   <= IDLE_FRAME;
            end

            if (state == S_LAUNCH && owner_vld) begin
                ptr <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            end

            tmo_cnt <= (state == S_WAIT) ? tmo_cnt + 1'b1 : '0;
            gap_cnt <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;

            if (eot_hit && owner_vld) done_q[owner] <= 1'b1;
            if (tmo_hit) begin
                abort_q <= 1'b1;
                err_q   <= 1'b1;
            end

            // Saturates while enable_i is low so the idle frame goes out as soon as it returns.
            if (!idle_ena_i || grant_go || idle_go) begin
                quiet_cnt <= '0;
            end else if (state == S_IDLE && !quiet_hit) begin
                quiet_cnt <= quiet_cnt + 1'b1;
            end
        end
    end

    assign done_o     = done_q;
    assign abort_o    = abort_q;
    assign err_o      = err_q;
    assign ser_data_o = {{(32 - FRAME_W){1'b0}}, frame_q};

endmodule

// File: tb/tb_serdes_tx_scheduler.sv
// Scoreboard bench: stimulus predicts each start/done/abort event (cycle and contents) from the
// arbitration and timing rules; a negedge monitor pops and compares whenever the DUT emits one.
module tb_serdes_tx_scheduler;
    import wb_sertx_sched_pkg::*;

    localparam int N     = 4;
    localparam int GAP   = 2;
    localparam int IDLEP = 64;
    localparam int TMO   = 1024;

    logic                 CLK_I = 1'b0;
    logic                 RST_I;
    logic                 enable_i, idle_ena_i, ser_eot_i;
    logic [N-1:0]         req_i;
    logic [N*FRAME_W-1:0] frame_i;
    logic [N-1:0]         gnt_o, done_o;
    logic                 ser_start_o, busy_o, err_o, abort_o;
    logic [31:0]          ser_data_o;

    serdes_tx_scheduler #(
        .NUM_REQ(N), .GAP_CYCLES(GAP), .IDLE_PERIOD(IDLEP), .TIMEOUT(TMO)
    ) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .enable_i(enable_i), .idle_ena_i(idle_ena_i),
        .req_i(req_i), .frame_i(frame_i), .gnt_o(gnt_o), .done_o(done_o),
        .ser_start_o(ser_start_o), .ser_data_o(ser_data_o), .ser_eot_i(ser_eot_i),
        .busy_o(busy_o), .err_o(err_o), .abort_o(abort_o)
    );

    always #5 CLK_I = ~CLK_I;

    int cyc = 0;
    always @(posedge CLK_I) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        logic         start;
        logic [N-1:0] gnt;
        logic [N-1:0] done;
        logic         abort;
        logic [31:0]  data;
        logic         err;
        logic         busy;
    } ev_t;

    ev_t          exp_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [26:0]  fr[N];
    int           ptr_m = 0;
    logic         err_m = 1'b0;
    int           idle_from = 0;
    logic [31:0]  last_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic ev_t mk_ev(int c, logic st, logic [N-1:0] g, logic [N-1:0] d,
                                  logic ab, logic [31:0] dat, logic er, logic bz);
        ev_t e;
        e.cyc = c; e.start = st; e.gnt = g; e.done = d;
        e.abort = ab; e.data = dat; e.err = er; e.busy = bz;
        return e;
    endfunction

    always @(negedge CLK_I) begin
        if (ser_start_o || done_o != '0 || abort_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: cycle %0d start=%b gnt=%b done=%b abort=%b, expected none",
                         cyc, ser_start_o, gnt_o, done_o, abort_o);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("event_cycle", cyc, e.cyc);
                chk("ser_start", ser_start_o, e.start);
                chk("gnt", gnt_o, e.gnt);
                chk("done", done_o, e.done);
                chk("abort", abort_o, e.abort);
                chk("ser_data", ser_data_o, e.data);
                chk("err", err_o, e.err);
                chk("busy", busy_o, e.busy);
            end
        end
    end

    task automatic step();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic set_frame(input int i, input logic [26:0] v);
        fr[i] = v;
        frame_i[i*FRAME_W +: FRAME_W] = v;
    endtask

    task automatic new_frames(input logic [N-1:0] add);
        for (int i = 0; i < N; i++)
            if (add[i] && !req_i[i]) set_frame(i, 27'($urandom));
    endtask

    // Raise requests once the lane is free; predict the round-robin winner and start cycle.
    task automatic launch(input logic [N-1:0] add, input int hold_off, input bit keep,
                          output int w, output int s);
        wait_until(idle_from);
        if (hold_off > 0) begin
            enable_i = 1'b0;
            req_i = req_i | add;
            repeat (hold_off) step();
        end
        req_i = req_i | add;
        enable_i = 1'b1;
        w = -1;
        for (int k = 0; k < N; k++)
            if (w < 0 && req_i[(ptr_m + k) % N]) w = (ptr_m + k) % N;
        s = cyc + 1;
        last_data = {5'b0, fr[w]};
        exp_q.push_back(mk_ev(s, 1'b1, N'(1) << w, '0, 1'b0, last_data, err_m, 1'b1));
        ptr_m = (w + 1) % N;
        step();
        if (keep) set_frame(w, 27'($urandom));
        else req_i[w] = 1'b0;
    endtask

    // dly = 0 means no eot at all; otherwise eot arrives dly cycles after start.
    task automatic finish(input int s, input int w, input int dly, input bit stray, input bit is_idle);
        if (dly == 0) begin
            int ab;
            ab = s + TMO + 1;
            exp_q.push_back(mk_ev(ab, 1'b0, '0, '0, 1'b1, last_data, 1'b1, GAP > 0));
            err_m = 1'b1;
            wait_until(ab);
            idle_from = ab + GAP;
        end else begin
            int e;
            e = s + dly;
            wait_until(e);
            ser_eot_i = 1'b1;
            if (!is_idle)
                exp_q.push_back(mk_ev(e + 1, 1'b0, '0, N'(1) << w, 1'b0, last_data, err_m, GAP > 0));
            step();
            if (stray) step();
            ser_eot_i = 1'b0;
            idle_from = e + 1 + GAP;
        end
    endtask

    initial begin
        int w, s, n, dly, r;
        logic [N-1:0] add;
        logic [8:0]   kc;
        logic [31:0]  idle_dat;

        RST_I = 1'b1; enable_i = 1'b0; idle_ena_i = 1'b0; ser_eot_i = 1'b0;
        req_i = '0; frame_i = '0;
        for (int i = 0; i < N; i++) fr[i] = '0;
        repeat (3) step();
        chk("rst_gnt", gnt_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_start", ser_start_o, 0);
        chk("rst_data", ser_data_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_abort", abort_o, 0);
        RST_I = 1'b0;
        enable_i = 1'b1;
        idle_from = cyc;

        // Single requester, then observe the gap.
        set_frame(1, {9'h000, 9'h012, 9'h034});
        launch(4'b0010, 0, 0, w, s);
        finish(s, w, 20, 0, 0);
        chk("gap_busy_0", busy_o, 1);
        step();
        chk("gap_busy_1", busy_o, 1);
        step();
        chk("gap_idle", busy_o, 0);

        // All requesters held; grants rotate.
        new_frames(4'b1111);
        launch(4'b1111, 0, 1, w, s);
        finish(s, w, $urandom_range(3, 10), 0, 0);
        for (int k = 0; k < 4; k++) begin
            launch(4'b0000, 0, 1, w, s);
            finish(s, w, $urandom_range(3, 10), 0, 0);
        end
        req_i = '0;

        // Idle-frame insertion after a quiet period.
        wait_until(idle_from);
        kc = 9'h1BC;
        idle_dat = {5'b0, kc, kc, kc};
        idle_ena_i = 1'b1;
        n = cyc;
        last_data = idle_dat;
        exp_q.push_back(mk_ev(n + IDLEP, 1'b1, '0, '0, 1'b0, idle_dat, err_m, 1'b1));
        wait_until(n + IDLEP);
        idle_ena_i = 1'b0;
        finish(n + IDLEP, 0, 12, 1, 1);

        // Eot exactly on the last wait cycle wins over the timeout.
        new_frames(4'b0001);
        launch(4'b0001, 0, 0, w, s);
        finish(s, w, TMO, 0, 0);

        // Full timeout, then the next request is still served with err sticky.
        new_frames(4'b0100);
        launch(4'b0100, 0, 0, w, s);
        finish(s, w, 0, 0, 0);
        new_frames(4'b1000);
        launch(4'b1000, 0, 0, w, s);
        finish(s, w, 5, 1, 0);

        // Held off by enable_i, a short-lived request during WAIT, enable dropped mid-frame.
        new_frames(4'b0100);
        launch(4'b0100, 8, 0, w, s);
        wait_until(s + 2);
        set_frame(3, 27'($urandom));
        req_i[3] = 1'b1;
        wait_until(s + 4);
        req_i[3] = 1'b0;
        enable_i = 1'b0;
        finish(s, w, 15, 0, 0);
        new_frames(4'b0001);
        launch(4'b0001, 0, 0, w, s);
        finish(s, w, 7, 0, 0);

        // Reset while waiting for eot: outputs clear, late eot ignored, pointer restarts.
        new_frames(4'b0010);
        launch(4'b0010, 0, 0, w, s);
        wait_until(s + 5);
        RST_I = 1'b1;
        step();
        chk("wrst_gnt", gnt_o, 0);
        chk("wrst_done", done_o, 0);
        chk("wrst_start", ser_start_o, 0);
        chk("wrst_data", ser_data_o, 0);
        chk("wrst_busy", busy_o, 0);
        chk("wrst_err", err_o, 0);
        chk("wrst_abort", abort_o, 0);
        RST_I = 1'b0;
        ser_eot_i = 1'b1;
        step();
        ser_eot_i = 1'b0;
        ptr_m = 0;
        err_m = 1'b0;
        idle_from = cyc;
        new_frames(4'b1111);
        launch(4'b1111, 0, 0, w, s);
        finish(s, w, 9, 0, 0);
        req_i = '0;

        // Randomized traffic.
        for (int it = 0; it < 30; it++) begin
            add = 4'($urandom);
            if ((req_i | add) == '0) add = N'(1) << $urandom_range(0, N - 1);
            new_frames(add);
            launch(add, 0, 1'($urandom), w, s);
            enable_i = 1'($urandom);
            r = $urandom_range(0, 19);
            if (r == 0) dly = 0;
            else if (r == 1) dly = TMO;
            else dly = $urandom_range(1, 30);
            finish(s, w, dly, 1'($urandom), 0);
        end
        req_i = '0;
        enable_i = 1'b1;
        repeat (20) step();
        chk("pending_events", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
